// File: rtl/cfg_pkg.sv
// -----------------------------------------------------------------------------
// cfg_pkg
//   Shared definitions for the configuration shadow bank:
//     DEFAULT_BASE - base of the per-register reset value
//     cfg_state_e  - commit sequencer states (IDLE, COMMIT)
//     default_val  - reset value of register i, truncated to w bits
// -----------------------------------------------------------------------------
package cfg_pkg;

  localparam int DEFAULT_BASE = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } cfg_state_e;

  // Reset value of register i: (DEFAULT_BASE + i) kept to the low w bits.
  function automatic int default_val(int i, int w);
    int mask;
    mask = (w >= 31) ? 32'h7fff_ffff : ((1 << w) - 1);
    return (DEFAULT_BASE + i) & mask;
  endfunction

endpackage

// File: rtl/cfg_shadow_bank.sv
// -----------------------------------------------------------------------------
// cfg_shadow_bank
//   Run-time configuration register bank with a shadow/active split.
//   Writes land in the shadow set; a commit copies shadow into the active set
//   one register per cycle; the active set is exported as a flat vector.
//
// Parameters
//   DATA_W   width of each register
//   NUM_REGS number of registers (>= 2)
//   ADDR_W   address width, derived from NUM_REGS (do not override)
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   wr_valid/wr_ready          write handshake (ready only while idle)
//   wr_addr, wr_data           write index and data
//   wr_err                     one-cycle pulse: previous accepted write rejected
//   rd_valid, rd_addr          read request (always accepted)
//   rd_resp_valid, rd_data     registered read response (shadow value)
//   rd_err                     read address was out of range
//   commit                     start copying shadow -> active
//   busy                       commit sequence in progress
//   commit_done                one-cycle pulse after the last register copied
//   active_q                   active set, reg i at [i*DATA_W +: DATA_W]
//
// Optional feature (macro CFG_SHADOW_LOCK_EN)
//   lock_set                   in IDLE, locks every register whose shadow
//                              differs from its active value
//   lock_q                     per-register lock flags, cleared only by reset
//   Writes to a locked register are rejected with wr_err.
// -----------------------------------------------------------------------------
module cfg_shadow_bank
  import cfg_pkg::default_val, cfg_pkg::cfg_state_e, cfg_pkg::IDLE, cfg_pkg::COMMIT;
#(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_err,
  input  logic                         rd_valid,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_resp_valid,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_err,
  input  logic                         commit,
  output logic                         busy,
  output logic                         commit_done,
  output logic [NUM_REGS*DATA_W-1:0]   active_q
`ifdef CFG_SHADOW_LOCK_EN
  ,
  input  logic                         lock_set,
  output logic [NUM_REGS-1:0]          lock_q
`endif
);

  // One extra bit so that NUM_REGS itself is representable for range checks.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W:0] LAST_IDX   = (ADDR_W + 1)'(NUM_REGS - 1);

  cfg_state_e          r_state;
  logic [ADDR_W:0]     r_idx;
  logic [DATA_W-1:0]   r_shadow [NUM_REGS];
  logic [DATA_W-1:0]   r_active [NUM_REGS];
  logic                r_wr_err;
  logic                r_rd_resp_valid;
  logic                r_rd_err;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_commit_done;

  logic                w_wr_fire;
  logic                w_wr_in_range;
  logic                w_wr_locked;
  logic                w_wr_reject;
  logic                w_rd_in_range;
  logic [DATA_W-1:0]   w_rd_shadow;

  assign w_wr_fire     = wr_valid && (r_state == IDLE);
  assign w_wr_in_range = ({1'b0, wr_addr} < NUM_REGS_W);
  assign w_rd_in_range = ({1'b0, rd_addr} < NUM_REGS_W);
  assign w_wr_reject   = !w_wr_in_range || w_wr_locked;

  // Read mux over the shadow set; an out-of-range address matches nothing
  // and therefore returns zero.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_rd_shadow = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        w_rd_shadow = r_shadow[i];
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values; this is what makes a same-cycle
  // read return the old shadow value and a same-cycle commit see the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_wr_err        <= 1'b0;
      r_rd_resp_valid <= 1'b0;
      r_rd_err        <= 1'b0;
      r_rd_data       <= '0;
      r_commit_done   <= 1'b0;
      // NOTE: the register arrays are reset element by element because each
      // entry has a defined default that downstream logic depends on; plain
      // storage arrays without a required value would be left unreset.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= DATA_W'(default_val(i, DATA_W));
        r_active[i] <= DATA_W'(default_val(i, DATA_W));
      end
    end else begin
      r_wr_err        <= w_wr_fire && w_wr_reject;
      r_rd_resp_valid <= rd_valid;
      r_rd_err        <= rd_valid && !w_rd_in_range;
      r_commit_done   <= 1'b0;

      if (rd_valid) begin
        r_rd_data <= w_rd_shadow;
      end

      if (w_wr_fire && !w_wr_reject) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_addr == ADDR_W'(i)) begin
            r_shadow[i] <= wr_data;
          end
        end
      end

      case (r_state)
        IDLE: begin
          if (commit) begin
            r_state <= COMMIT;
            r_idx   <= '0;
          end
        end
        COMMIT: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx == (ADDR_W + 1)'(i)) begin
              r_active[i] <= r_shadow[i];
            end
          end
          if (r_idx == LAST_IDX) begin
            r_state       <= IDLE;
            r_commit_done <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CFG_SHADOW_LOCK_EN
  logic [NUM_REGS-1:0] r_lock;

  always_comb begin
    w_wr_locked = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_addr == ADDR_W'(i)) begin
        w_wr_locked = r_lock[i];
      end
    end
  end

  // Locks are sticky: only reset clears them; commit does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock <= '0;
    end else if (lock_set && (r_state == IDLE)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_shadow[i] != r_active[i]) begin
          r_lock[i] <= 1'b1;
        end
      end
    end
  end

  assign lock_q = r_lock;
`else
  assign w_wr_locked = 1'b0;
`endif

  assign wr_ready      = (r_state == IDLE);
  assign busy          = (r_state == COMMIT);
  assign wr_err        = r_wr_err;
  assign rd_resp_valid = r_rd_resp_valid;
  assign rd_data       = r_rd_data;
  assign rd_err        = r_rd_err;
  assign commit_done   = r_commit_done;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_active
    assign active_q[g*DATA_W +: DATA_W] = r_active[g];
  end

endmodule

// File: tb/tb_cfg_shadow_bank.sv
`timescale 1ns/1ps
module tb_cfg_shadow_bank;

  localparam int DW  = 4;
  localparam int N   = 4;
  localparam int AW  = $clog2(N);
  localparam int N3  = 3;
  localparam int AW3 = $clog2(N3);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (NUM_REGS = 4)
  logic            rst, wr_valid, wr_ready, wr_err;
  logic            rd_valid, rd_resp_valid, rd_err;
  logic            commit, busy, commit_done;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [DW-1:0]   wr_data, rd_data;
  logic [N*DW-1:0] active_q;

  // Boundary instance (NUM_REGS = 3, so address 3 is out of range)
  logic             b_rst, b_wr_valid, b_wr_ready, b_wr_err;
  logic             b_rd_valid, b_rd_resp_valid, b_rd_err;
  logic             b_commit, b_busy, b_commit_done;
  logic [AW3-1:0]   b_wr_addr, b_rd_addr;
  logic [DW-1:0]    b_wr_data, b_rd_data;
  logic [N3*DW-1:0] b_active_q;

`ifdef CFG_SHADOW_LOCK_EN
  logic            lock_set;
  logic [N-1:0]    lock_q;
  logic            b_lock_set;
  logic [N3-1:0]   b_lock_q;
  logic [N-1:0]    m_lock;
`endif

  cfg_shadow_bank #(.DATA_W(DW), .NUM_REGS(N)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_resp_valid(rd_resp_valid),
    .rd_data(rd_data), .rd_err(rd_err),
    .commit(commit), .busy(busy), .commit_done(commit_done),
    .active_q(active_q)
`ifdef CFG_SHADOW_LOCK_EN
    , .lock_set(lock_set), .lock_q(lock_q)
`endif
  );

  cfg_shadow_bank #(.DATA_W(DW), .NUM_REGS(N3)) dut3 (
    .clk(clk), .rst(b_rst),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_err(b_wr_err),
    .rd_valid(b_rd_valid), .rd_addr(b_rd_addr), .rd_resp_valid(b_rd_resp_valid),
    .rd_data(b_rd_data), .rd_err(b_rd_err),
    .commit(b_commit), .busy(b_busy), .commit_done(b_commit_done),
    .active_q(b_active_q)
`ifdef CFG_SHADOW_LOCK_EN
    , .lock_set(b_lock_set), .lock_q(b_lock_q)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model of the main instance. A commit is a
  // countdown of N busy cycles after which the whole shadow set is copied.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m_shadow [N];
  logic [DW-1:0] m_active [N];
  int            m_left;
  logic          e_done, e_wr_err, e_rd_valid, e_rd_err;
  logic [DW-1:0] e_rd_data;

  function automatic logic [DW-1:0] def_val(int i);
    return DW'(5 + i);
  endfunction

  function automatic logic [N*DW-1:0] model_active();
    logic [N*DW-1:0] p;
    for (int i = 0; i < N; i++) p[i*DW +: DW] = m_active[i];
    return p;
  endfunction

  // Apply the current inputs to the model, advance one clock, compare.
  task automatic step();
    logic busy_now;
    logic locked;
    busy_now = 1'b0;
    locked   = 1'b0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_shadow[i] = def_val(i);
        m_active[i] = def_val(i);
      end
      m_left = 0; e_done = 0; e_wr_err = 0;
      e_rd_valid = 0; e_rd_err = 0; e_rd_data = '0;
`ifdef CFG_SHADOW_LOCK_EN
      m_lock = '0;
`endif
    end else begin
      busy_now   = (m_left > 0);
      e_rd_valid = rd_valid;
      e_rd_err   = rd_valid && (int'(rd_addr) >= N);
      if (rd_valid) e_rd_data = (int'(rd_addr) < N) ? m_shadow[rd_addr] : '0;
`ifdef CFG_SHADOW_LOCK_EN
      if (int'(wr_addr) < N) locked = m_lock[wr_addr];
      if (lock_set && !busy_now)
        for (int i = 0; i < N; i++)
          if (m_shadow[i] != m_active[i]) m_lock[i] = 1'b1;
`endif
      e_wr_err = 0;
      e_done   = 0;
      if (wr_valid && !busy_now) begin
        if (int'(wr_addr) >= N || locked) e_wr_err = 1;
        else m_shadow[wr_addr] = wr_data;
      end
      if (busy_now) begin
        m_left--;
        if (m_left == 0) begin
          for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
          e_done = 1;
        end
      end else if (commit) begin
        m_left = N;
      end
    end
    @(posedge clk); #1;
    check("busy", busy, (m_left > 0));
    check("wr_ready", wr_ready, (m_left == 0));
    check("commit_done", commit_done, e_done);
    check("wr_err", wr_err, e_wr_err);
    check("rd_resp_valid", rd_resp_valid, e_rd_valid);
    check("rd_err", rd_err, e_rd_err);
    check("rd_data", rd_data, e_rd_data);
    if (m_left == 0) check("active_q", active_q, model_active());
`ifdef CFG_SHADOW_LOCK_EN
    check("lock_q", lock_q, m_lock);
`endif
  endtask

  // Issue a commit (alongside any write already set up), then run until
  // commit_done with a bounded cycle budget. Returns observed busy cycles.
  task automatic run_commit(input string tag, output int nbusy);
    bit seen;
    seen  = 0;
    nbusy = 0;
    commit = 1'b1;
    step();
    commit   = 1'b0;
    wr_valid = 1'b0;
    if (busy) nbusy++;
    for (int k = 0; k < 4 * N && !seen; k++) begin
      step();
      if (commit_done) seen = 1;
      else if (busy) nbusy++;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
  endtask

  int nb;

  initial begin
    rst = 1'b1; wr_valid = 0; wr_addr = '0; wr_data = '0;
    rd_valid = 0; rd_addr = '0; commit = 0;
    b_rst = 1'b1; b_wr_valid = 0; b_wr_addr = '0; b_wr_data = '0;
    b_rd_valid = 0; b_rd_addr = '0; b_commit = 0;
`ifdef CFG_SHADOW_LOCK_EN
    lock_set = 0; b_lock_set = 0;
`endif

    // Reset and defaults
    step(); step();
    rst = 1'b0;
    check("reset_active", active_q, 16'h8765);
    rd_valid = 1; rd_addr = 2;
    step();
    rd_valid = 0;
    check("reset_read2", rd_data, 4'h7);

    // Write does not touch active; commit copies it
    wr_valid = 1; wr_addr = 1; wr_data = 4'hA;
    step();
    wr_valid = 0;
    check("write_no_active", active_q, 16'h8765);
    run_commit("commit1", nb);
    check("commit1_busy_cycles", nb, N);
    check("commit1_active", active_q, 16'h87A5);

    // Back-pressure: write presented while busy is held until accepted
    commit = 1;
    step();
    commit = 0;
    check("bp_ready_low", wr_ready, 1'b0);
    wr_valid = 1; wr_addr = 3; wr_data = 4'hC;
    rd_valid = 1; rd_addr = 3;
    step();
    rd_valid = 0;
    check("bp_shadow_kept", rd_data, 4'h8);
    for (int k = 0; k < 20 && !wr_ready; k++) step();
    check("bp_ready_returns", wr_ready, 1'b1);
    step();
    wr_valid = 0;
    rd_valid = 1; rd_addr = 3;
    step();
    rd_valid = 0;
    check("bp_write_landed", rd_data, 4'hC);

    // Write together with commit: copy includes the new value
    wr_valid = 1; wr_addr = 0; wr_data = 4'hF;
    run_commit("wr_commit", nb);
    check("wr_commit_reg0", active_q[3:0], 4'hF);

    // Read-before-write on the same address
    rd_valid = 1; rd_addr = 2; wr_valid = 1; wr_addr = 2; wr_data = 4'h3;
    step();
    rd_valid = 0; wr_valid = 0;
    check("rbw_old", rd_data, 4'h7);
    rd_valid = 1;
    step();
    rd_valid = 0;
    check("rbw_new", rd_data, 4'h3);

    // Reset on the second busy cycle
    commit = 1;
    step();
    commit = 0;
    step();
    check("midrst_busy_before", busy, 1'b1);
    rst = 1;
    step();
    rst = 0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", commit_done, 1'b0);
    check("midrst_active", active_q, 16'h8765);
    for (int k = 0; k < N + 2; k++) step();

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      rst      = ($urandom_range(0, 63) == 0);
      wr_valid = $urandom_range(0, 1);
      wr_addr  = AW'($urandom_range(0, N - 1));
      wr_data  = DW'($urandom);
      rd_valid = $urandom_range(0, 1);
      rd_addr  = AW'($urandom_range(0, N - 1));
      commit   = ($urandom_range(0, 7) == 0);
      step();
    end
    rst = 0; wr_valid = 0; rd_valid = 0; commit = 0;
    for (int k = 0; k < N + 2; k++) step();

`ifdef CFG_SHADOW_LOCK_EN
    // Lock a register whose shadow differs, then try to rewrite it
    rst = 1; step(); rst = 0;
    wr_valid = 1; wr_addr = 1; wr_data = 4'h2;
    step();
    wr_valid = 0;
    lock_set = 1;
    step();
    lock_set = 0;
    check("lock_reg1", lock_q, 4'b0010);
    wr_valid = 1; wr_addr = 1; wr_data = 4'h4;
    step();
    wr_valid = 0;
    check("lock_wr_err", wr_err, 1'b1);
    rd_valid = 1; rd_addr = 1;
    step();
    rd_valid = 0;
    check("lock_retained", rd_data, 4'h2);
`endif

    // Boundary instance: NUM_REGS = 3
    step(); step();
    b_rst = 0;
    check("b_reset_active", b_active_q, 12'h765);
    b_wr_valid = 1; b_wr_addr = 3; b_wr_data = 4'h9;
    step();
    b_wr_valid = 0;
    check("b_wr_err_pulse", b_wr_err, 1'b1);
    step();
    check("b_wr_err_clear", b_wr_err, 1'b0);
    b_rd_valid = 1; b_rd_addr = 3;
    step();
    check("b_rd_resp_valid", b_rd_resp_valid, 1'b1);
    check("b_rd_err", b_rd_err, 1'b1);
    check("b_rd_data_zero", b_rd_data, 4'h0);
    for (int i = 0; i < N3; i++) begin
      b_rd_addr = AW3'(i);
      step();
      check("b_rd_unchanged", b_rd_data, DW'(5 + i));
      check("b_rd_err_inrange", b_rd_err, 1'b0);
    end
    b_rd_valid = 0;
    b_commit = 1;
    step();
    b_commit = 0;
    nb = 0;
    for (int k = 0; k < 12 && !b_commit_done; k++) begin
      if (b_busy) nb++;
      step();
    end
    check("b_commit_done", b_commit_done, 1'b1);
    check("b_busy_cycles", nb, N3);
    check("b_active_after", b_active_q, 12'h765);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfg_shadow_bank.md
Name: cfg_shadow_bank

Overview:
Parametrised configuration register bank. Generalises fixed package-level constants into NUM_REGS run-time-writable registers of DATA_W bits each. Every register resets to a package-defined default.
- Writes land in a shadow copy.
- A commit request copies the shadow set into the active set, one register per cycle.
- The active set drives downstream logic as a flat vector.

Parameters:
- DATA_W, 4, width of each register.
- NUM_REGS, 4, number of registers (>=2).
- ADDR_W, $clog2(NUM_REGS), address width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write can be accepted (1 in IDLE only).
- wr_addr  in  ADDR_W  write register index.
- wr_data  in  DATA_W  write data.
- wr_err  out  1  one-cycle pulse: previous accepted write was rejected.
- rd_valid  in  1  read request (always accepted).
- rd_addr  in  ADDR_W  read register index.
- rd_resp_valid  out  1  read response strobe.
- rd_data  out  DATA_W  shadow value of the addressed register.
- rd_err  out  1  read address out of range (with rd_resp_valid).
- commit  in  1  commit request pulse.
- busy  out  1  commit in progress.
- commit_done  out  1  one-cycle pulse when the last register has been copied.
- active_q  out  NUM_REGS*DATA_W  active registers; reg i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - shadow[i] = active[i] = cfg_pkg::default_val(i), i.e. (DEFAULT_BASE+i) mod 2^DATA_W. With defaults this gives 5,6,7,8.
  - All strobes/pulses, busy and rd_data are 0; wr_ready = 1; state = IDLE.
- FSM states: IDLE, COMMIT.
  - IDLE -> COMMIT on commit=1; idx counter cleared to 0.
  - COMMIT: each cycle, active[idx] <= shadow[idx] and idx increments.
  - When idx==NUM_REGS-1: copy, pulse commit_done next cycle, return to IDLE.
  - busy = (state==COMMIT), so busy is high for exactly NUM_REGS cycles.
- Write rules:
  - Accepted when wr_valid && wr_ready.
  - shadow[wr_addr] updates at that clock edge.
  - wr_addr >= NUM_REGS: no register changes; wr_err=1 the following cycle.
  - wr_ready=0 in COMMIT; writes presented then are not accepted and must be held by the source.
- Read rules:
  - Latency 1. rd_resp_valid and rd_data are registered from rd_valid and rd_addr.
  - Reads are allowed in any state.
  - Out-of-range rd_addr: rd_data=0, rd_err=1.
- Simultaneous events:
  - Write and commit in the same IDLE cycle: the write is accepted and the commit starts. The copy includes the new value.
  - Write and read to the same address in the same cycle: read returns the OLD value (read-before-write).
  - commit while busy: ignored (not queued).
- Mid-operation events:
  - Reset during COMMIT: all registers return to defaults, FSM returns to IDLE, commit_done is not pulsed.
- Arithmetic: idx is ADDR_W+1 bits wide, so NUM_REGS that is a power of two cannot wrap.
- active_q changes only during COMMIT or reset, never directly on a write.

Optional Feature:
Macro CFG_SHADOW_LOCK_EN.
- Defined:
  - Adds input lock_set (1) and output lock_q (NUM_REGS).
  - lock_set=1 in IDLE sets lock_q[i]=1 for every i where shadow[i] != active[i].
  - A write to a locked register is rejected: no update, wr_err pulse.
  - lock_q resets to 0 and clears only on reset.
  - Commit still copies locked registers.
- Undefined: no lock ports, no lock state; all in-range writes are accepted.

Decomposition:
- Package cfg_pkg contains:
  - localparam DEFAULT_BASE = 5.
  - Enum typedef cfg_state_e {IDLE, COMMIT}.
  - Function default_val(int i, int w) returning (DEFAULT_BASE+i) truncated to w bits.
- Import cfg_pkg by explicit item (cfg_pkg::default_val, cfg_pkg::cfg_state_e), not by wildcard.
- No sub-module; a single module is natural.

Test Plan:
- Reset, defaults: assert rst 2 cycles -> active_q = {8,7,6,5} (reg3..reg0); reading addr 2 returns rd_data=7 one cycle later.
- Write then commit: write reg1=0xA -> active_q unchanged. Commit -> busy for 4 cycles, commit_done on the 5th cycle, active reg1=0xA.
- Back-pressure: wr_valid during busy -> wr_ready=0 and no shadow change. Hold request until IDLE -> accepted.
- Boundary: NUM_REGS=3, write addr 3 -> wr_err pulse, no change. Read addr 3 -> rd_err=1, rd_data=0.
- Simultaneous events:
  - Write reg0=0xF together with commit -> active reg0=0xF after commit_done.
  - Read and write to reg2 in the same cycle -> read returns 7.
- Reset mid-commit: assert rst on the 2nd busy cycle -> defaults restored, busy=0, no commit_done. (Feature build: lock reg1 after a differing write; next write to reg1 -> wr_err, value retained.)
